serpent_decrypt_pipe: RTL and testbench
=======================================

// Module: serpent_decrypt_pipe
// PURPOSE
//  Fully pipelined Serpent-256 block decryptor: one 128-bit ciphertext per clock
//   in, one 128-bit plaintext per clock out, 32 cycles later.
//  Consumes the 33 round subkeys from the key_gen block (the same keys bus that
//   feeds encryption). Sits directly behind encryption in the crypto datapath.
//  Purely datapath: no handshake, no valid flags. Data streams every cycle.
// PARAMETERS
//  none  - round count (32), subkey count (33) and block width (128) are fixed
//          constants held in the shared package.
// PORTS
//  clk          in   1       rising-edge clock; the only clock
//  rst          in   1       reset; asynchronous, active-high
//  input_data   in   128     ciphertext block; sampled every rising edge
//  keys         in   4224    33 subkeys; K_i = keys[128*i +: 128], i = 0..32
//  output_data  out  128     plaintext block; registered
// BEHAVIOUR
//  Word/bit order (bitslice mode, matches encryption/key_gen):
//   - X0 = [31:0], X1 = [63:32], X2 = [95:64], X3 = [127:96].
//   - Applies to both data and each K_i.
//  Decryption algorithm, stages s = 0..31, round r = 31 - s:
//   - s = 0: B = InvS_7(input_data ^ K32) ^ K31.
//   - s >= 1: B = InvS_(r mod 8)(InvLT(B)) ^ K_r.
//   - After s = 31 (r = 0), B is the plaintext.
//  InvS_n: standard Serpent inverse S-box n, applied bitsliced.
//   - Nibble j is built from bit j of X3,X2,X1,X0 (MSB..LSB).
//   - InvS0 = {13,3,11,0,10,6,5,12,1,14,4,7,15,9,8,2}; InvS1..InvS7 per the
//     Serpent standard.
//  InvLT (ror = rotate right, << = logical shift left, 32-bit):
//   - X2 = ror(X2,22); X0 = ror(X0,5); X2 ^= X3 ^ (X1<<7); X0 ^= X1 ^ X3;
//   - X3 = ror(X3,7);  X1 = ror(X1,1); X3 ^= X2 ^ (X0<<3); X1 ^= X0 ^ X2;
//   - X2 = ror(X2,3);  X0 = ror(X0,13).
//  Pipeline:
//   - One 128-bit register after each of the 32 stages.
//   - The stage-31 register drives output_data.
//   - Latency: exactly 32 rising edges from sampling input_data to output_data.
//   - Throughput: 1 block/cycle. Back-to-back blocks never interact.
//  Keys:
//   - Not pipelined; each stage reads its K_r combinationally at the current edge.
//   - keys must be stable while blocks are in flight. A key change mid-stream
//     corrupts in-flight blocks; no detection is required.
//  Reset:
//   - While rst is high, all 32 stage registers and output_data are 0 (async
//     clear, immediate).
//   - For the first 31 edges after release, output_data carries deterministic
//     flush values (decryption of zero stages). Consumers must ignore them.
//   - Reset mid-stream discards all in-flight blocks.
//  No X propagation: all registers are reset; there are no latches.
// STRUCTURE
//  Shared package serpent_pkg:
//   - NUM_ROUNDS = 32, NUM_KEYS = 33, BLK_W = 128.
//   - Inverse S-box table function inv_sbox(n, nibble).
//   - inv_lt function.
//   - Word-slicing helper.
//  One sub-module, serpent_round_inv:
//   - Ports: round index (constant), 128b in, first-round flag, K_r, K32; 128b out.
//   - Purely combinational: optional InvLT, InvS, key XOR.
//  Top: generate loop of 32 serpent_round_inv instances, each followed by an
//   async-reset register.
// TESTING
//  Common setup:
//   - Wire key_gen -> encryption -> serpent_decrypt_pipe.
//   - Key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f.
//   - Clock period 10.
//  1 Plaintext 128'h...deadbeef held constant
//    -> after encryption latency + 32 cycles, output_data = 128'h...deadbeef,
//       and it stays stable.
//  2 Back-to-back plaintexts 128'h...b05902109, ...b05902110 .. ...b05902114
//    (one per cycle) -> same sequence appears on output_data on consecutive
//    cycles, in order.
//  3 Assert rst for 3 cycles mid-stream
//    -> output_data = 0 immediately, without waiting for a clock edge;
//    -> after release, plaintexts for blocks fed after release appear 32
//       cycles after sampling, bit-exact.
//  4 Single-stage check: drive input_data = K32 ^ S7-image of (0 ^ K31)
//    -> compare stage-0 register against a software model, then confirm full
//       32-cycle latency by counting edges to first correct output.
//  5 Random streaming: 1000 random blocks and a random key, compared against a
//    reference Serpent model -> zero mismatches, no X on output after reset.

Source files
------------

// File: rtl/serpent_pkg.sv
// Shared Serpent constants and the bitsliced helpers used by the inverse round datapath.
// Word order: X0 = [31:0] .. X3 = [127:96]; nibble j is {X3[j],X2[j],X1[j],X0[j]}.
package serpent_pkg;

    localparam int NUM_ROUNDS = 32;
    localparam int NUM_KEYS   = 33;
    localparam int BLK_W      = 128;
    localparam int WORD_W     = 32;
    localparam int KEYS_W     = NUM_KEYS * BLK_W;

    typedef logic [BLK_W-1:0]  blk_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam logic [3:0] INV_SBOX_TBL [8][16] = '{
        '{4'd13, 4'd3,  4'd11, 4'd0,  4'd10, 4'd6,  4'd5,  4'd12,
          4'd1,  4'd14, 4'd4,  4'd7,  4'd15, 4'd9,  4'd8,  4'd2},
        '{4'd5,  4'd8,  4'd2,  4'd14, 4'd15, 4'd6,  4'd12, 4'd3,
          4'd11, 4'd4,  4'd7,  4'd9,  4'd1,  4'd13, 4'd10, 4'd0},
        '{4'd12, 4'd9,  4'd15, 4'd4,  4'd11, 4'd14, 4'd1,  4'd2,
          4'd0,  4'd3,  4'd6,  4'd13, 4'd5,  4'd8,  4'd10, 4'd7},
        '{4'd0,  4'd9,  4'd10, 4'd7,  4'd11, 4'd14, 4'd6,  4'd13,
          4'd3,  4'd5,  4'd12, 4'd2,  4'd4,  4'd8,  4'd15, 4'd1},
        '{4'd5,  4'd0,  4'd8,  4'd3,  4'd10, 4'd9,  4'd7,  4'd14,
          4'd2,  4'd12, 4'd11, 4'd6,  4'd4,  4'd15, 4'd13, 4'd1},
        '{4'd8,  4'd15, 4'd2,  4'd9,  4'd4,  4'd1,  4'd13, 4'd14,
          4'd11, 4'd6,  4'd5,  4'd3,  4'd7,  4'd12, 4'd10, 4'd0},
        '{4'd15, 4'd10, 4'd1,  4'd13, 4'd5,  4'd3,  4'd6,  4'd0,
          4'd4,  4'd9,  4'd14, 4'd7,  4'd2,  4'd12, 4'd8,  4'd11},
        '{4'd3,  4'd0,  4'd6,  4'd13, 4'd9,  4'd14, 4'd15, 4'd8,
          4'd5,  4'd12, 4'd11, 4'd7,  4'd10, 4'd1,  4'd4,  4'd2}
    };

    function automatic logic [3:0] inv_sbox(input logic [2:0] n, input logic [3:0] nib);
        return INV_SBOX_TBL[n][nib];
    endfunction

    function automatic word_t get_word(input blk_t b, input int unsigned idx);
        return b[WORD_W*idx +: WORD_W];
    endfunction

    function automatic blk_t pack_words(input word_t x0, input word_t x1,
                                        input word_t x2, input word_t x3);
        return {x3, x2, x1, x0};
    endfunction

    function automatic word_t ror32(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic blk_t inv_lt(input blk_t b);
        word_t x0, x1, x2, x3;
        x0 = get_word(b, 0);
        x1 = get_word(b, 1);
        x2 = get_word(b, 2);
        x3 = get_word(b, 3);
        x2 = ror32(x2, 22);
        x0 = ror32(x0, 5);
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = x0 ^ x1 ^ x3;
        x3 = ror32(x3, 7);
        x1 = ror32(x1, 1);
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = x1 ^ x0 ^ x2;
        x2 = ror32(x2, 3);
        x0 = ror32(x0, 13);
        return pack_words(x0, x1, x2, x3);
    endfunction

    // The same 4-bit inverse S-box is applied to all 32 bit columns in parallel.
    function automatic blk_t inv_sbox_blk(input logic [2:0] n, input blk_t b);
        word_t      x0, x1, x2, x3;
        word_t      y0, y1, y2, y3;
        logic [3:0] o;
        x0 = get_word(b, 0);
        x1 = get_word(b, 1);
        x2 = get_word(b, 2);
        x3 = get_word(b, 3);
        y0 = '0;
        y1 = '0;
        y2 = '0;
        y3 = '0;
        for (int j = 0; j < WORD_W; j++) begin
            o     = inv_sbox(n, {x3[j], x2[j], x1[j], x0[j]});
            y0[j] = o[0];
            y1[j] = o[1];
            y2[j] = o[2];
            y3[j] = o[3];
        end
        return pack_words(y0, y1, y2, y3);
    endfunction

endpackage

// File: rtl/serpent_decrypt_pipe_if.sv
// Datapath bundle for the decryptor: ciphertext and subkey bus in, plaintext out.
// Free-running stream: no valid/ready, one block per clock in each direction.
interface serpent_decrypt_pipe_if;
    import serpent_pkg::*;

    blk_t              input_data;
    logic [KEYS_W-1:0] keys;
    blk_t              output_data;

    modport master (output input_data, output keys, input output_data);
    modport slave  (input input_data, input keys, output output_data);

endinterface

// File: rtl/serpent_round_inv.sv
// One combinational Serpent decryption stage: optional InvLT (or K32 pre-whitening
// on the first stage), inverse S-box of the round, then XOR with the round subkey.
module serpent_round_inv
    import serpent_pkg::*;
(
    input  logic [4:0] round_i,
    input  logic       first_i,
    input  blk_t       blk_i,
    input  blk_t       key_r_i,
    input  blk_t       key_last_i,
    output blk_t       blk_o
);

    blk_t       pre_sbox;
    logic [1:0] unused_round_hi;

    // Only round mod 8 selects the S-box; the upper index bits carry no logic.
    assign unused_round_hi = round_i[4:3];

    always_comb begin
        pre_sbox = first_i ? (blk_i ^ key_last_i) : inv_lt(blk_i);
        blk_o    = inv_sbox_blk(round_i[2:0], pre_sbox) ^ key_r_i;
    end

endmodule

// File: rtl/serpent_decrypt_pipe.sv
// Fully pipelined Serpent-256 decryptor: 32 inverse-round stages, each registered,
// one block per clock with a fixed 32-edge latency. Subkeys are read unregistered.
module serpent_decrypt_pipe
    import serpent_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    serpent_decrypt_pipe_if.slave dp
);

    blk_t key_last;

    assign key_last = dp.keys[BLK_W*(NUM_KEYS-1) +: BLK_W];

    // Stage s undoes encryption round r = 31 - s.
    for (genvar s = 0; s < NUM_ROUNDS; s++) begin : g_stage
        localparam int R = NUM_ROUNDS - 1 - s;

        blk_t stage_in;
        blk_t stage_d;
        blk_t stage_q;

        if (s == 0) begin : g_head
            assign stage_in = dp.input_data;
        end else begin : g_body
            assign stage_in = g_stage[s-1].stage_q;
        end

        serpent_round_inv u_round (
            .round_i    (5'(R)),
            .first_i    (s == 0),
            .blk_i      (stage_in),
            .key_r_i    (dp.keys[BLK_W*R +: BLK_W]),
            .key_last_i (key_last),
            .blk_o      (stage_d)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end
    end

    assign dp.output_data = g_stage[NUM_ROUNDS-1].stage_q;

endmodule

// File: tb/tb_serpent_decrypt_pipe.sv
// Bench for serpent_decrypt_pipe: ciphertexts come from a forward Serpent model
// over random subkeys, and the recovered plaintext is checked 32 edges later.
module tb_serpent_decrypt_pipe;
  import serpent_pkg::*;

  localparam int LAT = 32;

  localparam int SBOX_TBL [8][16] = '{
    '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
    '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
    '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
    '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
    '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
    '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
    '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
    '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
  };

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serpent_decrypt_pipe_if dp ();

  serpent_decrypt_pipe dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp)
  );

  int errors = 0;
  int checks = 0;

  logic [127:0] sk [NUM_KEYS];
  logic [127:0] exp_q[$];
  bit           chk_q[$];

  // checker
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // forward Serpent reference (encryption direction)
  function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] sbox_fwd(input int n, input logic [127:0] b);
    logic [31:0] x [4];
    logic [31:0] y [4];
    logic [3:0]  v;
    for (int w = 0; w < 4; w++) begin
      x[w] = b[32*w +: 32];
      y[w] = '0;
    end
    for (int j = 0; j < 32; j++) begin
      v = 4'(SBOX_TBL[n][{x[3][j], x[2][j], x[1][j], x[0][j]}]);
      for (int w = 0; w < 4; w++) y[w][j] = v[w];
    end
    return {y[3], y[2], y[1], y[0]};
  endfunction

  function automatic logic [127:0] lt_fwd(input logic [127:0] b);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = b;
    x0 = rol32(x0, 13);
    x2 = rol32(x2, 3);
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rol32(x1, 1);
    x3 = rol32(x3, 7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rol32(x0, 5);
    x2 = rol32(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  // Runs encryption rounds 0..nr-1; nr = 32 gives the full ciphertext.
  function automatic logic [127:0] enc_rounds(input logic [127:0] pt, input int nr);
    logic [127:0] b;
    b = pt;
    for (int r = 0; r < nr; r++) begin
      b = sbox_fwd(r % 8, b ^ sk[r]);
      if (r < 31) b = lt_fwd(b);
      else        b = b ^ sk[32];
    end
    return b;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // driver tasks
  task automatic load_keys();
    for (int i = 0; i < NUM_KEYS; i++) begin
      sk[i] = rand128();
      dp.keys[128*i +: 128] = sk[i];
    end
  endtask

  task automatic step(input string tag, input logic [127:0] pt, input bit do_chk);
    logic [127:0] e;
    bit           c;
    @(negedge clk);
    if (exp_q.size() == LAT) begin
      e = exp_q.pop_front();
      c = chk_q.pop_front();
      if (c) check_eq(tag, dp.output_data, e);
    end
    dp.input_data = enc_rounds(pt, 32);
    exp_q.push_back(pt);
    chk_q.push_back(do_chk);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async", dp.output_data, '0);
    repeat (ncyc) begin
      @(negedge clk);
      check_eq("rst_hold", dp.output_data, '0);
    end
    rst = 1'b0;
    exp_q.delete();
    chk_q.delete();
  endtask

  // main sequence
  initial begin
    logic [127:0] ct1, pt2, inter2, ct2;
    int           edges;
    bit           found;
    logic [127:0] b2b [6];

    b2b[0] = 128'hb05902109;
    b2b[1] = 128'hb05902110;
    b2b[2] = 128'hb05902111;
    b2b[3] = 128'hb05902112;
    b2b[4] = 128'hb05902113;
    b2b[5] = 128'hb05902114;

    dp.input_data = '0;
    dp.keys       = '0;
    load_keys();
    #1;
    check_eq("rst_init", dp.output_data, '0);
    repeat (3) @(negedge clk);
    check_eq("rst_init_hold", dp.output_data, '0);
    rst = 1'b0;

    // constant plaintext: output must settle and stay on it
    for (int i = 0; i < LAT + 10; i++) step("const", 128'hdeadbeef, 1'b1);

    // back-to-back sequence, then random traffic across a mid-stream reset
    for (int i = 0; i < 6; i++) step("b2b", b2b[i], 1'b1);
    for (int i = 0; i < LAT + 4; i++) step("pre_rst", rand128(), 1'b1);
    do_reset(3);
    for (int i = 0; i < 20; i++) step("post_rst", rand128(), 1'b1);
    for (int i = 0; i < LAT; i++) step("post_rst", rand128(), 1'b0);

    // single-stage check and latency count
    do_reset(2);
    ct1    = sbox_fwd(7, sk[31]) ^ sk[32];
    pt2    = rand128();
    inter2 = enc_rounds(pt2, 31);
    ct2    = enc_rounds(pt2, 32);
    @(negedge clk);
    dp.input_data = ct1;
    @(negedge clk);
    check_eq("stage0_zero", dut.g_stage[0].stage_q, '0);
    dp.input_data = ct2;
    edges = 0;
    found = 1'b0;
    while (!found && edges < LAT + 8) begin
      @(negedge clk);
      edges++;
      if (edges == 1) check_eq("stage0_model", dut.g_stage[0].stage_q, inter2);
      dp.input_data = rand128();
      if (dp.output_data === pt2) found = 1'b1;
    end
    check_eq("latency", 128'(edges), 128'(LAT));

    // random streaming under a fresh key set
    load_keys();
    do_reset(2);
    for (int i = 0; i < 1000; i++) begin
      step("random", rand128(), 1'b1);
      check_eq("no_x", {127'b0, $isunknown(dp.output_data)}, '0);
    end
    for (int i = 0; i < LAT; i++) step("random", rand128(), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
